// File: rtl/bank_stream_reader_pkg.sv
// Shared definitions for the bank stream reader: FSM encoding, default
// widths and the prefetch FIFO entry layout {data, last}.
package bank_stream_reader_pkg;

  localparam int ADDR_WIDTH_DEF = 13;
  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  // FIFO entry carries the data word plus its last-beat tag in the LSB
  function automatic int entry_width(input int data_width);
    return data_width + 1;
  endfunction

endpackage

// File: rtl/bank_stream_reader_stream_fifo.sv
// Synchronous FIFO with registered pointers and an occupancy count.
// A simultaneous push and pop on a full FIFO is legal and keeps the count.
module stream_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are qualified by count so no reset is needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Credit logic upstream must never push into a full FIFO without a pop
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && full && !do_pop))
        else $error("stream_fifo: push into full FIFO");
    end
  end

endmodule

// File: rtl/bank_stream_reader.sv
// Read master for one feature-map bank: fetches a contiguous burst over a
// 1-cycle-latency read port and streams it out with valid/ready and a last
// marker. Reads are credit-limited so the prefetch FIFO never overflows.
module bank_stream_reader
  import bank_stream_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_csen,
  output logic                  mem_rdena,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  localparam int EW = entry_width(DATA_WIDTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_V = (CW+1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_LEFT = (ADDR_WIDTH+1)'(1);

  state_t                state;
  state_t                state_nx;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic [ADDR_WIDTH:0]   rem_cnt;
  logic                  vld_p1;
  logic                  last_p1;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty;
  logic [EW-1:0]         head;
  logic [CW:0]           occupancy;
  logic                  credit_ok;
  logic                  start_ok;
  logic                  last_issue;
  logic                  pop;

  assign start_ok   = start && (state == IDLE);
  assign occupancy  = {1'b0, fifo_count} + {{CW{1'b0}}, vld_p1};
  assign credit_ok  = occupancy < DEPTH_V;
  assign last_issue = mem_rdena && (rem_cnt == ONE_LEFT);
  assign pop        = m_valid && m_ready;

  assign mem_csen = mem_rdena;
  assign mem_addr = mem_rdena ? addr_p0 : '0;
  assign m_valid  = !fifo_empty;
  assign m_data   = m_valid ? head[EW-1:1] : '0;
  assign m_last   = m_valid && head[0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (length == '0) ? FIN : FETCH;
      FETCH:   if (last_issue) state_nx = DRAIN;
      DRAIN:   if (pop && m_last) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Read issue: only in FETCH, only with FIFO credit and words left
  always_comb begin
    mem_rdena = 1'b0;
    if (state == FETCH && credit_ok && rem_cnt != '0) mem_rdena = 1'b1;
  end

  // --- stage p0: issue address and remaining-word count ---
  always_ff @(posedge clk) begin
    if (start_ok)       addr_p0 <= base_addr;
    else if (mem_rdena) addr_p0 <= addr_p0 + 1'b1;
  end

  // Remaining issues gate the read enable, so it is reset with control
  always_ff @(posedge clk) begin
    if (rst)            rem_cnt <= '0;
    else if (start_ok)  rem_cnt <= length;
    else if (mem_rdena) rem_cnt <= rem_cnt - 1'b1;
  end

  // --- stage p1: read in flight, data lands on mem_data this cycle ---
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      vld_p1  <= mem_rdena;
      last_p1 <= last_issue;
    end
  end

  // Busy spans accepted start through the done pulse; done follows FIN
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= (state == FIN);
      if (start_ok)  busy <= 1'b1;
      else if (done) busy <= 1'b0;
    end
  end

  stream_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (vld_p1),
    .push_data ({mem_data, last_p1}),
    .pop       (pop),
    .pop_data  (head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_bank_stream_reader.sv
// Directed bench for bank_stream_reader. The bank model returns word[i]=i
// (low byte) one cycle after a read. A negedge monitor records stream
// beats, read addresses and protocol violations; the main sequence checks.
module tb_bank_stream_reader;

  localparam int AW = 13;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          busy, done, mem_csen, mem_rdena;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_last;

  int checks = 0;
  int failures = 0;
  logic clr = 1'b0;

  int rd_seen = 0, valid_seen = 0, done_seen = 0;
  int credit_viol = 0, stab_viol = 0, csen_viol = 0, max_occ = 0;
  int occ_cnt = 0, occ_inf = 0;
  logic prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic prev_last = 1'b0;
  logic [8:0]    rx_q[$];
  logic [AW-1:0] addr_q[$];

  bank_stream_reader #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .mem_csen  (mem_csen),
    .mem_rdena (mem_rdena),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last)
  );

  always #5 clk = ~clk;

  // Bank model: registered read, zero when not enabled
  always @(posedge clk) mem_data <= (mem_rdena === 1'b1) ? mem_addr[DW-1:0] : '0;

  // Monitor: sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      occ_cnt   <= 0;
      occ_inf   <= 0;
      prev_hold <= 1'b0;
    end else begin
      if (clr) begin
        rd_seen <= 0; valid_seen <= 0; done_seen <= 0;
        credit_viol <= 0; stab_viol <= 0; csen_viol <= 0; max_occ <= 0;
        rx_q.delete();
        addr_q.delete();
      end else begin
        if (mem_csen !== mem_rdena) csen_viol <= csen_viol + 1;
        if (mem_rdena === 1'b1) begin
          rd_seen <= rd_seen + 1;
          addr_q.push_back(mem_addr);
          if (occ_cnt + occ_inf >= 4) credit_viol <= credit_viol + 1;
        end
        if (occ_cnt + occ_inf > max_occ) max_occ <= occ_cnt + occ_inf;
        if (m_valid === 1'b1) valid_seen <= valid_seen + 1;
        if (done === 1'b1) done_seen <= done_seen + 1;
        if (prev_hold && (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last))
          stab_viol <= stab_viol + 1;
        if (m_valid === 1'b1 && m_ready === 1'b1) rx_q.push_back({m_last, m_data});
      end
      occ_cnt   <= occ_cnt + occ_inf - ((m_valid === 1'b1 && m_ready === 1'b1) ? 1 : 0);
      occ_inf   <= (mem_rdena === 1'b1) ? 1 : 0;
      prev_hold <= (m_valid === 1'b1) && !m_ready;
      prev_data <= m_data;
      prev_last <= m_last;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] l);
    base_addr = b;
    length    = l;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic wait_done(input int max, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    logic [8:0] exp9;

    // Reset state
    rst = 1'b1;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rdena", mem_rdena, 0);
    chk("rst_csen", mem_csen, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_last", m_last, 0);
    rst = 1'b0;
    step();

    // Basic burst, full throughput
    clear_mon();
    m_ready = 1'b1;
    do_start(13'h010, 14'd5);
    chk("b_busy_c1", busy, 1);
    chk("b_rdena_c1", mem_rdena, 1);
    chk("b_addr_c1", mem_addr, 13'h010);
    chk("b_valid_c1", m_valid, 0);
    step();
    chk("b_valid_c2", m_valid, 0);
    chk("b_addr_c2", mem_addr, 13'h011);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("b_valid", m_valid, 1);
      chk("b_data", m_data, 8'h10 + 8'(i));
      chk("b_last", m_last, (i == 4) ? 1 : 0);
      step();
    end
    chk("b_valid_end", m_valid, 0);
    chk("b_done_early", done, 0);
    step();
    chk("b_done", done, 1);
    chk("b_busy_at_done", busy, 1);
    step();
    chk("b_done_drop", done, 0);
    chk("b_busy_drop", busy, 0);
    chk("b_done_count", done_seen, 1);
    chk("b_csen", csen_viol, 0);

    // Backpressure with ready pattern 1,0,0,1
    clear_mon();
    do_start(13'h100, 14'd12);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      m_ready = (k % 4 == 0) || (k % 4 == 3);
      step();
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    m_ready = 1'b1;
    chk("bp_done_seen", ok, 1);
    step();
    chk("bp_busy_after", busy, 0);
    chk("bp_count", rx_q.size(), 12);
    for (int i = 0; i < 12; i++) begin
      exp9 = {(i == 11), 8'(i)};
      chk("bp_word", (i < rx_q.size()) ? rx_q[i] : 9'h1ff, exp9);
    end
    chk("bp_credit", credit_viol, 0);
    chk("bp_max_occ", max_occ, 4);
    chk("bp_stable", stab_viol, 0);
    chk("bp_reads", rd_seen, 12);
    chk("bp_done_count", done_seen, 1);

    // Zero-length command
    clear_mon();
    do_start(13'h055, 14'd0);
    chk("z_busy_c1", busy, 1);
    chk("z_done_c1", done, 0);
    step();
    chk("z_done_c2", done, 1);
    chk("z_busy_c2", busy, 1);
    step();
    chk("z_done_c3", done, 0);
    chk("z_busy_c3", busy, 0);
    step();
    chk("z_reads", rd_seen, 0);
    chk("z_valid", valid_seen, 0);
    chk("z_done_count", done_seen, 1);

    // Address wrap at the top of the bank
    clear_mon();
    m_ready = 1'b1;
    do_start(13'h1FFE, 14'd4);
    wait_done(40, ok);
    chk("w_done_seen", ok, 1);
    step();
    chk("w_addr_count", addr_q.size(), 4);
    chk("w_addr0", (addr_q.size() > 0) ? addr_q[0] : 13'h0AAA, 13'h1FFE);
    chk("w_addr1", (addr_q.size() > 1) ? addr_q[1] : 13'h0AAA, 13'h1FFF);
    chk("w_addr2", (addr_q.size() > 2) ? addr_q[2] : 13'h0AAA, 13'h0000);
    chk("w_addr3", (addr_q.size() > 3) ? addr_q[3] : 13'h0AAA, 13'h0001);
    chk("w_data_count", rx_q.size(), 4);
    chk("w_data0", (rx_q.size() > 0) ? rx_q[0] : 9'h1aa, 9'h0FE);
    chk("w_data1", (rx_q.size() > 1) ? rx_q[1] : 9'h1aa, 9'h0FF);
    chk("w_data2", (rx_q.size() > 2) ? rx_q[2] : 9'h1aa, 9'h000);
    chk("w_data3", (rx_q.size() > 3) ? rx_q[3] : 9'h1aa, 9'h101);
    chk("w_busy_after", busy, 0);

    // Start ignored during FETCH, then reset while draining
    clear_mon();
    m_ready = 1'b0;
    do_start(13'h230, 14'd3);
    chk("r_rdena_c1", mem_rdena, 1);
    chk("r_addr_c1", mem_addr, 13'h230);
    do_start(13'h300, 14'd2);
    chk("r_addr_c2", mem_addr, 13'h231);
    step();
    chk("r_rdena_c3", mem_rdena, 1);
    chk("r_addr_c3", mem_addr, 13'h232);
    step();
    chk("r_rdena_drain", mem_rdena, 0);
    chk("r_valid_drain", m_valid, 1);
    chk("r_data_drain", m_data, 8'h30);
    chk("r_busy_drain", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("r_valid_after_rst", m_valid, 0);
    chk("r_busy_after_rst", busy, 0);
    chk("r_done_after_rst", done, 0);
    for (int i = 0; i < 5; i++) step();
    chk("r_no_done", done_seen, 0);
    chk("r_no_valid", m_valid, 0);

    // Fresh burst after reset completes normally
    clear_mon();
    m_ready = 1'b1;
    do_start(13'h000, 14'd3);
    wait_done(40, ok);
    chk("f_done_seen", ok, 1);
    step();
    chk("f_count", rx_q.size(), 3);
    chk("f_word0", (rx_q.size() > 0) ? rx_q[0] : 9'h1aa, 9'h000);
    chk("f_word1", (rx_q.size() > 1) ? rx_q[1] : 9'h1aa, 9'h001);
    chk("f_word2", (rx_q.size() > 2) ? rx_q[2] : 9'h1aa, 9'h102);
    chk("f_done_count", done_seen, 1);
    chk("f_busy_after", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bank_stream_reader.md
Name: bank_stream_reader

Overview:
- Read-side master for one feature-map memory bank. Each read port has 1-cycle registered latency and returns 0 when not enabled.
- On a start command it fetches a contiguous burst of words (base address, length) over the bank read port.
- It presents the words as a valid/ready stream to the PE array, with last-beat marking.
- Internal prefetch FIFO with credit control keeps the bank read port busy without losing words under backpressure.

Parameters:
- ADDR_WIDTH, 13, bank address width; addresses wrap modulo 2^ADDR_WIDTH
- DATA_WIDTH, 8, word width
- FIFO_DEPTH, 4, prefetch FIFO entries; power of two, >=2

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle command pulse; sampled only in IDLE
- base_addr  in  ADDR_WIDTH  first word address, captured on accepted start
- length  in  ADDR_WIDTH+1  number of words, 0..2^ADDR_WIDTH, captured on accepted start
- busy  out  1  high from accepted start until done pulse, inclusive
- done  out  1  one-cycle pulse when burst completes
- mem_csen  out  1  bank chip select, equal to mem_rdena
- mem_rdena  out  1  bank read enable
- mem_addr  out  ADDR_WIDTH  bank read address
- mem_data  in  DATA_WIDTH  bank read data, valid the cycle after mem_rdena
- m_valid  out  1  stream word valid
- m_ready  in  1  downstream accept
- m_data  out  DATA_WIDTH  stream word
- m_last  out  1  marks final word of burst

Behaviour:
- Reset (rst=1 at posedge): all outputs 0; FSM to IDLE; FIFO emptied; in-flight flag cleared. Reset mid-burst abandons the burst with no done pulse.
- FSM states: IDLE, FETCH, DRAIN, FIN.
- IDLE:
  - start=1 with length>0: capture base_addr and length, set busy, go to FETCH.
  - start=1 with length=0: set busy, go to FIN. No reads are issued.
  - start in any other state is ignored.
- FETCH, issue rule:
  - mem_rdena=1 in a cycle iff (FIFO count + inflight) < FIFO_DEPTH and remaining issues > 0.
  - mem_addr = base + issued count, truncated to ADDR_WIDTH (wraps 2^ADDR_WIDTH-1 -> 0).
  - When the last issue is made, go to DRAIN.
- Capture: inflight is a registered copy of mem_rdena. When inflight=1, push {mem_data, is_last} into the FIFO that cycle. is_last=1 for the length-th issued word.
- Credit guarantees the FIFO never overflows. A push into a full FIFO is a design error; an assertion fires.
- DRAIN: no reads. When the FIFO pop has m_last=1 and m_ready=1, go to FIN.
- FIN: done=1 for exactly one cycle, then IDLE. busy drops in the cycle after FIN.
- Stream side:
  - m_valid = FIFO not empty; m_data and m_last come from the FIFO head.
  - Pop on m_valid & m_ready.
  - Once m_valid is high, m_data and m_last are held stable until accepted.
- Simultaneous push and pop on the same cycle, including on a full FIFO: both occur, count unchanged.
- Throughput: with m_ready held at 1, one word per cycle sustained. The first m_valid appears 2 cycles after the accepted start (issue cycle + read latency).
- length = 2^ADDR_WIDTH reads the whole bank once, starting from base_addr and wrapping.

Decomposition:
- Shared package holds:
  - FSM state encoding constants (IDLE, FETCH, DRAIN, FIN)
  - default widths: ADDR_WIDTH=13, DATA_WIDTH=8
  - the FIFO entry width expression DATA_WIDTH+1
- One sub-module: stream_fifo. It is a synchronous FIFO with parameters WIDTH and DEPTH, registered pointers, a count output, and a rst port of the same style.
- Issue counter, remaining counter and credit logic stay in the top module.

Test Plan:
- Basic burst: preload bank with word[i]=i; start with base=0x010, length=5; m_ready=1. Expect m_data 0x10..0x14 on 5 consecutive cycles; m_last only on 0x14; a single done pulse; busy low afterwards.
- Backpressure: base=0x100, length=12; m_ready toggles 1,0,0,1 repeating.
  - All 12 words arrive in order with no loss or duplication.
  - m_data stays stable while m_ready=0.
  - mem_rdena never asserts when count+inflight=4.
- Zero length: start with length=0. Expect mem_rdena never high, m_valid never high, done pulse 2 cycles after start, busy high for 2 cycles.
- Address wrap: base=0x1FFE, length=4. Expect mem_addr sequence 0x1FFE, 0x1FFF, 0x0000, 0x0001 and the corresponding data in order.
- Start ignored / reset mid-op: pulse start again during FETCH, which must be ignored. Then assert rst during DRAIN with 2 words buffered. Next cycle: m_valid=0, busy=0, done never pulses. A fresh start afterwards, base=0, length=3, completes normally.
